// File: rtl/memcpy_job_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | memcpy_job_queue : job FIFO + single-job sequencer for the memcpy engine  |
// | Optional watchdog macro: MEMCPY_JOBQ_TIMEOUT_EN          Rev 1.0          |
// +--------------------------------------------------------------------------+
module memcpy_job_queue #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DEPTH_LOG2     = 2,
  parameter int DONE_GUARD     = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_WIDTH-1:0] job_src_addr,
  input  logic [ADDR_WIDTH-1:0] job_tgt_addr,
  input  logic [63:0]           job_len,
  input  logic [7:0]            job_tag,
  output logic [ADDR_WIDTH-1:0] memcpy_src_addr,
  output logic [ADDR_WIDTH-1:0] memcpy_tgt_addr,
  output logic [63:0]           memcpy_len,
  output logic                  memcpy_start,
  input  logic                  memcpy_done,
  output logic                  cmpl_valid,
  input  logic                  cmpl_ready,
  output logic [7:0]            cmpl_tag,
  output logic [1:0]            cmpl_status,
  output logic [DEPTH_LOG2:0]   queue_level,
  output logic                  busy,
  output logic [31:0]           cmpl_count
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [3:0]        GUARD_LAST = 4'(DONE_GUARD - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ZERO    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_ARM       = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_COMPLETE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0] fifo_src [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_tgt [DEPTH];
  logic [63:0]           fifo_len [DEPTH];
  logic [7:0]            fifo_tag [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   level_next;
  logic                  push, pop;

  logic [63:0] job_len_q;
  logic [7:0]  job_tag_q;
  logic [3:0]  guard_cnt;
  logic        guard_done;
  logic        timeout;
  logic [1:0]  status_next;

  assign push       = job_valid & job_ready;
  assign pop        = (state == S_IDLE) && (queue_level != '0);
  assign level_next = queue_level + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
  assign guard_done = (guard_cnt == GUARD_LAST);
  assign cmpl_valid = (state == S_COMPLETE);
  assign busy       = (state != S_IDLE) || (queue_level != '0);

  // FIFO and job registers; engine operands only change when a real copy is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_src[i] <= '0;
        fifo_tgt[i] <= '0;
        fifo_len[i] <= '0;
        fifo_tag[i] <= '0;
      end
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      queue_level     <= '0;
      job_ready       <= 1'b0;
      job_len_q       <= '0;
      job_tag_q       <= '0;
      memcpy_src_addr <= '0;
      memcpy_tgt_addr <= '0;
      memcpy_len      <= '0;
    end else begin
      if (push) begin
        fifo_src[wr_ptr] <= job_src_addr;
        fifo_tgt[wr_ptr] <= job_tgt_addr;
        fifo_len[wr_ptr] <= job_len;
        fifo_tag[wr_ptr] <= job_tag;
        wr_ptr           <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop) begin
        job_len_q <= fifo_len[rd_ptr];
        job_tag_q <= fifo_tag[rd_ptr];
        if (fifo_len[rd_ptr] != '0) begin
          memcpy_src_addr <= fifo_src[rd_ptr];
          memcpy_tgt_addr <= fifo_tgt[rd_ptr];
          memcpy_len      <= fifo_len[rd_ptr];
        end
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      queue_level <= level_next;
      job_ready   <= (level_next != FULL_LEVEL);
    end
  end

`ifdef MEMCPY_JOBQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_active;

  assign to_active = (state == S_ARM) || (state == S_WAIT_DONE);
  assign timeout   = to_active && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state == S_LAUNCH) begin
      to_cnt <= '0;
    end else if (to_active && !timeout) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    status_next  = cmpl_status;
    memcpy_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (job_len_q == '0) begin
          status_next = ST_ZERO;
          state_next  = S_COMPLETE;
        end else begin
          memcpy_start = 1'b1;
          state_next   = S_ARM;
        end
      end
      // memcpy_done is deliberately ignored here: it may still be high from the last job.
      S_ARM: begin
        if (timeout) begin
          status_next = ST_TIMEOUT;
          state_next  = S_COMPLETE;
        end else if (guard_done) begin
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (memcpy_done) begin
          status_next = ST_OK;
          state_next  = S_COMPLETE;
        end else if (timeout) begin
          status_next = ST_TIMEOUT;
          state_next  = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        if (cmpl_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      guard_cnt   <= '0;
      cmpl_tag    <= '0;
      cmpl_status <= '0;
      cmpl_count  <= '0;
    end else begin
      if (state == S_LAUNCH) begin
        guard_cnt <= '0;
      end else if (state == S_ARM) begin
        guard_cnt <= guard_cnt + 4'd1;
      end
      if (state_next == S_COMPLETE && state != S_COMPLETE) begin
        cmpl_tag    <= job_tag_q;
        cmpl_status <= status_next;
      end
      if (cmpl_valid && cmpl_ready) begin
        cmpl_count <= cmpl_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memcpy_job_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_memcpy_job_queue : scoreboard bench for memcpy_job_queue  Rev 1.0      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_memcpy_job_queue;

  localparam int AW = 64;
  localparam int DL = 2;
  localparam int DG = 2;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [AW-1:0] job_src_addr, job_tgt_addr;
  logic [63:0]   job_len;
  logic [7:0]    job_tag;
  logic [AW-1:0] memcpy_src_addr, memcpy_tgt_addr;
  logic [63:0]   memcpy_len;
  logic          memcpy_start;
  logic          memcpy_done = 1'b0;
  logic          cmpl_valid;
  logic          cmpl_ready;
  logic [7:0]    cmpl_tag;
  logic [1:0]    cmpl_status;
  logic [DL:0]   queue_level;
  logic          busy;
  logic [31:0]   cmpl_count;

  memcpy_job_queue #(
    .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .DONE_GUARD(DG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_src_addr(job_src_addr), .job_tgt_addr(job_tgt_addr),
    .job_len(job_len), .job_tag(job_tag),
    .memcpy_src_addr(memcpy_src_addr), .memcpy_tgt_addr(memcpy_tgt_addr),
    .memcpy_len(memcpy_len), .memcpy_start(memcpy_start), .memcpy_done(memcpy_done),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
    .cmpl_tag(cmpl_tag), .cmpl_status(cmpl_status),
    .queue_level(queue_level), .busy(busy), .cmpl_count(cmpl_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [191:0] exp_launch [$];
  logic [9:0]   exp_cmpl   [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Engine model: drops done on start (unless holding a stale level), raises it later.
  int eng_delay = 20;
  bit eng_stall = 0;
  bit eng_hold  = 0;
  int eng_cnt   = -1;
  always @(negedge clk) begin
    if (rst) begin
      memcpy_done = 1'b0;
      eng_cnt     = -1;
    end else if (memcpy_start) begin
      if (!eng_hold) memcpy_done = 1'b0;
      eng_cnt = eng_delay;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
    end else if (eng_cnt == 0 && !eng_stall) begin
      memcpy_done = 1'b1;
      eng_cnt     = -1;
    end
  end

  // Monitor: launches and completions are checked against the scoreboard queues.
  int hs_count  = 0;
  int n_starts  = 0;
  int start_cyc = 0;
  bit in_flight = 0;
  bit prev_valid = 0;
  bit check_lat = 0;
  always @(negedge clk) begin
    logic [191:0] l;
    logic [9:0]   c;
    if (rst) begin
      hs_count   = 0;
      in_flight  = 0;
      prev_valid = 0;
    end else begin
      if (memcpy_start) begin
        n_starts++;
        start_cyc = cyc;
        chk("one_in_flight", 64'(in_flight), 64'd0);
        chk("launch_expected", 64'(exp_launch.size() != 0), 64'd1);
        if (exp_launch.size() != 0) begin
          l = exp_launch.pop_front();
          chk("launch_src", memcpy_src_addr, l[191:128]);
          chk("launch_tgt", memcpy_tgt_addr, l[127:64]);
          chk("launch_len", memcpy_len, l[63:0]);
        end
        in_flight = 1;
      end
      if (cmpl_valid && !prev_valid && check_lat)
        chk("guard_latency", 64'(cyc - start_cyc), 64'(DG + 2));
      if (cmpl_valid && cmpl_ready) begin
        chk("cmpl_expected", 64'(exp_cmpl.size() != 0), 64'd1);
        if (exp_cmpl.size() != 0) begin
          c = exp_cmpl.pop_front();
          chk("cmpl_tag", cmpl_tag, c[9:2]);
          chk("cmpl_status", cmpl_status, c[1:0]);
        end
        chk("cmpl_count", cmpl_count, 64'(hs_count));
        hs_count++;
        in_flight = 0;
      end
      prev_valid = cmpl_valid;
    end
  end

  task automatic push_job(input logic [63:0] s, input logic [63:0] t, input logic [63:0] len,
                          input logic [7:0] tg, input logic [1:0] st);
    int w = 0;
    job_valid = 1'b1; job_src_addr = s; job_tgt_addr = t; job_len = len; job_tag = tg;
    while (!job_ready && w < 300) begin
      @(posedge clk); #1; w++;
    end
    chk("push_accept", 64'(w < 300), 64'd1);
    if (w < 300) begin
      @(posedge clk); #1;
      if (len != 0) exp_launch.push_back({s, t, len});
      exp_cmpl.push_back({tg, st});
    end
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while (!(exp_cmpl.size() == 0 && !busy) && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    chk(name, 64'(w < 3000), 64'd1);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_start"},  64'(memcpy_start), 64'd0);
    chk({name, "_src"},    memcpy_src_addr, 64'd0);
    chk({name, "_tgt"},    memcpy_tgt_addr, 64'd0);
    chk({name, "_len"},    memcpy_len, 64'd0);
    chk({name, "_cvalid"}, 64'(cmpl_valid), 64'd0);
    chk({name, "_ctag"},   64'(cmpl_tag), 64'd0);
    chk({name, "_cstat"},  64'(cmpl_status), 64'd0);
    chk({name, "_level"},  64'(queue_level), 64'd0);
    chk({name, "_busy"},   64'(busy), 64'd0);
    chk({name, "_count"},  64'(cmpl_count), 64'd0);
  endtask

  initial begin
    int w;
    int starts_before;
    rst = 1'b1; job_valid = 1'b0; cmpl_ready = 1'b1;
    job_src_addr = '0; job_tgt_addr = '0; job_len = '0; job_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(job_ready), 64'd0);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(job_ready), 64'd1);

    // Single job through the engine.
    push_job(64'h1000, 64'h8000, 64'd256, 8'h11, 2'b00);
    job_valid = 1'b0;
    wait_drain("drain_single");
    chk("count_after_single", 64'(cmpl_count), 64'd1);

    // Five jobs with the engine stalled: one in flight, four queued, FIFO full.
    eng_stall = 1;
    push_job(64'h2000, 64'h9000, 64'd16,  8'h01, 2'b00);
    push_job(64'h2100, 64'h9100, 64'd32,  8'h02, 2'b00);
    push_job(64'h2200, 64'h9200, 64'd48,  8'h03, 2'b00);
    push_job(64'h2300, 64'h9300, 64'd64,  8'h04, 2'b00);
    push_job(64'h2400, 64'h9400, 64'd80,  8'h05, 2'b00);
    job_valid = 1'b0;
    chk("full_level", 64'(queue_level), 64'd4);
    chk("full_ready", 64'(job_ready), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("full_level_held", 64'(queue_level), 64'd4);
    chk("busy_while_full", 64'(busy), 64'd1);
    eng_stall = 0;
    wait_drain("drain_five");
    chk("ready_after_drain", 64'(job_ready), 64'd1);
    chk("count_after_five", 64'(cmpl_count), 64'd6);

    // Stale done level held through launch must be masked by the guard window.
    eng_hold = 1; check_lat = 1;
    push_job(64'h3000, 64'hA000, 64'd8, 8'h33, 2'b00);
    job_valid = 1'b0;
    wait_drain("drain_stale");
    eng_hold = 0; check_lat = 0;

    // Zero-length job never reaches the engine.
    starts_before = n_starts;
    push_job(64'h4000, 64'hB000, 64'd0, 8'h22, 2'b01);
    job_valid = 1'b0;
    wait_drain("drain_zero");
    chk("zero_no_start", 64'(n_starts - starts_before), 64'd0);

    // Completion back-pressure with a second job queued.
    eng_delay = 5; cmpl_ready = 1'b0;
    push_job(64'h5000, 64'hC000, 64'd64,  8'h41, 2'b00);
    push_job(64'h5100, 64'hC100, 64'd128, 8'h42, 2'b00);
    job_valid = 1'b0;
    w = 0;
    while (!cmpl_valid && w < 200) begin
      @(posedge clk); #1; w++;
    end
    chk("bp_valid_seen", 64'(w < 200), 64'd1);
    starts_before = n_starts;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 64'(cmpl_valid), 64'd1);
      chk("bp_tag_hold", 64'(cmpl_tag), 64'h41);
    end
    chk("bp_no_start", 64'(n_starts - starts_before), 64'd0);
    chk("bp_count_hold", 64'(cmpl_count), 64'd8);
    cmpl_ready = 1'b1;
    wait_drain("drain_bp");
    chk("bp_count_final", 64'(cmpl_count), 64'd10);
    eng_delay = 20;

    // Reset during WAIT_DONE discards the in-flight job and the queue.
    eng_stall = 1;
    push_job(64'h6000, 64'hD000, 64'd32, 8'h51, 2'b00);
    push_job(64'h6100, 64'hD100, 64'd32, 8'h52, 2'b00);
    push_job(64'h6200, 64'hD200, 64'd32, 8'h53, 2'b00);
    job_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_level", 64'(queue_level), 64'd2);
    rst = 1'b1;
    exp_launch.delete();
    exp_cmpl.delete();
    @(posedge clk); #1;
    chk("midrst_ready", 64'(job_ready), 64'd0);
    check_reset_outputs("midrst");
    rst = 1'b0; eng_stall = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(busy), 64'd0);
    chk("post_rst_count", 64'(cmpl_count), 64'd0);
    chk("post_rst_ready", 64'(job_ready), 64'd1);

`ifdef MEMCPY_JOBQ_TIMEOUT_EN
    eng_stall = 1;
    push_job(64'h7000, 64'hE000, 64'd32, 8'h61, 2'b10);
    job_valid = 1'b0;
    wait_drain("drain_timeout");
    eng_stall = 0;
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("final_count", 64'(cmpl_count), 64'(hs_count));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
